// File: rtl/ctrl_pkg.sv
// Shared constants for the MIPS-subset control automaton: opcodes, ALU
// function codes, FSM state encodings and the instruction legality check.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef logic [2:0] state_t;

  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_WB     = 3'd3;
  localparam state_t S_HALT   = 3'd4;

  // R-type is legal only with one of the five supported funct codes.
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: ok = 1'b1;
          default:                          ok = 1'b0;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ, OP_BNE: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ctrl_aut_if.sv
// Control bundle between ctrl_aut (master) and the datapath (slave).
interface ctrl_aut_if #(
  parameter int CountWidth = 16
);
  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic                  zero;
  logic                  rd_mux_s;
  logic                  write;
  logic                  op2_mux_s;
  logic [5:0]            alu_funct;
  logic                  branch_mux_s;
  logic                  pc_load;
  logic                  halted;
  logic [CountWidth-1:0] instr_count;

  modport master (
    input  opcode, funct, zero,
    output rd_mux_s, write, op2_mux_s, alu_funct, branch_mux_s, pc_load,
           halted, instr_count
  );

  modport slave (
    output opcode, funct, zero,
    input  rd_mux_s, write, op2_mux_s, alu_funct, branch_mux_s, pc_load,
           halted, instr_count
  );
endinterface

// File: rtl/ctrl_aut_alu_decoder.sv
// Combinational decode of the latched instruction into ALU/mux controls.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [5:0] alu_funct,
  output logic       op2_mux_s,
  output logic       rd_mux_s,
  output logic       is_branch,
  output logic       is_bne,
  output logic       illegal
);

  // Opcode table; branches compare via subtract.
  always_comb begin
    alu_funct = 6'h00;
    op2_mux_s = 1'b0;
    rd_mux_s  = 1'b0;
    is_branch = 1'b0;
    is_bne    = 1'b0;
    illegal   = !is_legal(opcode, funct);
    case (opcode)
      OP_RTYPE: begin
        alu_funct = funct;
        rd_mux_s  = 1'b1;
      end
      OP_ADDI: begin
        alu_funct = F_ADD;
        op2_mux_s = 1'b1;
      end
      OP_ANDI: begin
        alu_funct = F_AND;
        op2_mux_s = 1'b1;
      end
      OP_ORI: begin
        alu_funct = F_OR;
        op2_mux_s = 1'b1;
      end
      OP_BEQ: begin
        alu_funct = F_SUB;
        is_branch = 1'b1;
      end
      OP_BNE: begin
        alu_funct = F_SUB;
        is_branch = 1'b1;
        is_bne    = 1'b1;
      end
      default: alu_funct = 6'h00;
    endcase
  end

endmodule

// File: rtl/ctrl_aut.sv
// Multi-cycle FETCH/DECODE/EXEC/WB controller with sticky illegal-opcode halt
// and a retired-instruction counter.
module ctrl_aut
  import ctrl_pkg::*;
#(
  parameter int CountWidth = 16
) (
  input  logic       clock,
  input  logic       reset,
  ctrl_aut_if.master bus
);

  localparam logic [CountWidth-1:0] COUNT_ONE = {{(CountWidth-1){1'b0}}, 1'b1};

  state_t                state_r;
  state_t                next_state_s;
  logic [5:0]            opcode_r;
  logic [5:0]            funct_r;
  logic [CountWidth-1:0] count_r;
  logic                  halted_r;

  logic [5:0] dec_funct_s;
  logic       dec_op2_s;
  logic       dec_rd_s;
  logic       dec_branch_s;
  logic       dec_bne_s;
  logic       dec_illegal_s;
  logic       live_legal_s;

  logic [5:0] alu_funct_s;
  logic       op2_mux_s_s;
  logic       rd_mux_s_s;
  logic       branch_mux_s_s;
  logic       write_s;
  logic       pc_load_s;

  alu_decoder u_dec (
    .opcode    (opcode_r),
    .funct     (funct_r),
    .alu_funct (dec_funct_s),
    .op2_mux_s (dec_op2_s),
    .rd_mux_s  (dec_rd_s),
    .is_branch (dec_branch_s),
    .is_bne    (dec_bne_s),
    .illegal   (dec_illegal_s)
  );

  // Legality is judged on the live inputs in DECODE, before the IR shadow loads.
  assign live_legal_s = is_legal(bus.opcode, bus.funct);

  // Next-state logic; a corrupted IR shadow in EXEC is treated as illegal.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH:  next_state_s = S_DECODE;
      S_DECODE: begin
        if (live_legal_s) begin
          next_state_s = S_EXEC;
        end else begin
          next_state_s = S_HALT;
        end
      end
      S_EXEC: begin
        if (dec_illegal_s) begin
          next_state_s = S_HALT;
        end else if (dec_branch_s) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_WB;
        end
      end
      S_WB:     next_state_s = S_FETCH;
      S_HALT:   next_state_s = S_HALT;
      default:  next_state_s = S_FETCH;
    endcase
  end

  // Output decode from state and IR shadow; branch_mux_s follows zero in EXEC.
  always_comb begin
    alu_funct_s    = 6'h00;
    op2_mux_s_s    = 1'b0;
    rd_mux_s_s     = 1'b0;
    branch_mux_s_s = 1'b0;
    write_s        = 1'b0;
    pc_load_s      = 1'b0;
    case (state_r)
      S_EXEC: begin
        alu_funct_s = dec_funct_s;
        op2_mux_s_s = dec_op2_s;
        rd_mux_s_s  = dec_rd_s;
        if (dec_branch_s && !dec_illegal_s) begin
          branch_mux_s_s = bus.zero ^ dec_bne_s;
          pc_load_s      = 1'b1;
        end else begin
          branch_mux_s_s = 1'b0;
          pc_load_s      = 1'b0;
        end
      end
      S_WB: begin
        alu_funct_s = dec_funct_s;
        op2_mux_s_s = dec_op2_s;
        rd_mux_s_s  = dec_rd_s;
        write_s     = 1'b1;
        pc_load_s   = 1'b1;
      end
      default: begin
        alu_funct_s = 6'h00;
      end
    endcase
  end

  // State, IR shadow, retire counter and sticky halt flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= S_FETCH;
      opcode_r <= 6'h00;
      funct_r  <= 6'h00;
      count_r  <= {CountWidth{1'b0}};
      halted_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (state_r == S_DECODE) begin
        opcode_r <= bus.opcode;
        funct_r  <= bus.funct;
      end
      if (pc_load_s) begin
        count_r <= count_r + COUNT_ONE;
      end
      if (next_state_s == S_HALT) begin
        halted_r <= 1'b1;
      end
    end
  end

  assign bus.alu_funct    = alu_funct_s;
  assign bus.op2_mux_s    = op2_mux_s_s;
  assign bus.rd_mux_s     = rd_mux_s_s;
  assign bus.branch_mux_s = branch_mux_s_s;
  assign bus.write        = write_s;
  assign bus.pc_load      = pc_load_s;
  assign bus.halted       = halted_r;
  assign bus.instr_count  = count_r;

endmodule

// File: doc/ctrl_aut.md
# ctrl_aut

Multi-cycle control automaton for the MIPS-subset datapath. Consumes `opcode`, `funct` and `zero` from the datapath and sequences its control inputs over a FETCH/DECODE/EXEC/WB state machine. It adds an explicit PC-load strobe, a sticky halt on illegal opcodes, and a retired-instruction counter. Sits beside the datapath in the CPU top level as its sole control source.

## Interface
- `CountWidth`, 16: width of the retired-instruction counter.
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  instruction[31:26] from datapath.
- `funct`  in  6  instruction[5:0] from datapath.
- `zero`  in  1  ALU zero flag from datapath.
- `rd_mux_s`  out  1  write-register select: 0 = rt, 1 = rd.
- `write`  out  1  register-file write enable.
- `op2_mux_s`  out  1  ALU operand 2 select: 0 = rdata2, 1 = sign-extended imm.
- `alu_funct`  out  6  ALU operation, in R-type funct encoding.
- `branch_mux_s`  out  1  next-PC select: 0 = PC+4, 1 = branch target.
- `pc_load`  out  1  PC register load enable.
- `halted`  out  1  sticky illegal-opcode flag.
- `instr_count`  out  CountWidth  instructions retired since reset.

## Operation
- Supported opcodes:
  - R-type 6'h00: `alu_funct` = latched funct.
  - ADDI 6'h08: `alu_funct` = 6'h20.
  - ANDI 6'h0C: `alu_funct` = 6'h24.
  - ORI 6'h0D: `alu_funct` = 6'h25.
  - BEQ 6'h04: `alu_funct` = 6'h22.
  - BNE 6'h05: `alu_funct` = 6'h22.
- R-type funct accepted: 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A. Any other funct, or any other opcode, is illegal.
- FETCH: all strobes 0. Next state is DECODE.
- DECODE:
  - Latch `opcode` and `funct` into internal IR shadow registers.
  - If illegal, go to HALT; otherwise go to EXEC.
- EXEC: drive `alu_funct`, `op2_mux_s` and `rd_mux_s` from the latched opcode.
  - `op2_mux_s` = 1 for ADDI/ANDI/ORI; 0 for R-type and branches.
  - `rd_mux_s` = 1 for R-type only.
  - Branch: `branch_mux_s` = `zero` (BEQ) or `!zero` (BNE), combinational from `zero` in this state only. `pc_load` = 1, `instr_count` increments, next state is FETCH.
  - Non-branch: next state is WB.
- WB:
  - `write` = 1 and `pc_load` = 1, with `branch_mux_s` = 0.
  - `alu_funct`, `op2_mux_s` and `rd_mux_s` hold their EXEC values.
  - `instr_count` increments; next state is FETCH.
- HALT: all strobes 0, `halted` = 1. The block stays here until reset.
- `instr_count` wraps from all-ones to 0 silently.

## Timing
- Reset (async assert): state = FETCH; IR shadow = 0; `instr_count` = 0; `halted` = 0. All outputs are 0, including `alu_funct` = 6'h00.
- Reset deassertion: first FETCH occupies the first rising edge after `reset` goes high.
- Reset mid-instruction: abandons immediately. No `write` or `pc_load` is issued for the partial instruction.
- Latency per instruction:
  - R-type and I-type: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Branch: 3 cycles.
- `pc_load` is high exactly one cycle per retired instruction. That cycle coincides with WB, or with EXEC for branches.
- `write` is never high outside WB; `write` and `branch_mux_s` are never high together.
- All outputs are Moore (registered state plus IR shadow), except `branch_mux_s`, which is Mealy on `zero` during EXEC.
- `instr_count` updates on the same edge that ends the `pc_load` cycle.
- `opcode` and `funct` changes outside DECODE have no effect.
- Illegal instruction: `halted` rises on the edge leaving DECODE; the count is not incremented.

## Structure
- Shared package `ctrl_pkg`:
  - Opcode constants OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ, OP_BNE.
  - ALU funct constants F_ADD, F_SUB, F_AND, F_OR, F_SLT.
  - State enum S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT.
- One combinational sub-module, `alu_decoder`:
  - Inputs: latched opcode and funct.
  - Outputs: `alu_funct`, `op2_mux_s`, `rd_mux_s`, `is_branch`, `is_bne`, `illegal`.
- FSM, IR shadow, counter and halt flag live in `ctrl_aut`.

## Test plan
- Reset then R-type ADD (opcode 0, funct 6'h20):
  - EXEC: `alu_funct`=6'h20, `op2_mux_s`=0, `rd_mux_s`=1.
  - WB: `write`=1 and `pc_load`=1 in cycle 4; `instr_count`=1.
- ORI (6'h0D):
  - EXEC: `alu_funct`=6'h25, `op2_mux_s`=1, `rd_mux_s`=0.
  - WB: `write` pulses one cycle.
- BEQ with `zero`=1, then BNE with `zero`=1:
  - BEQ: `branch_mux_s`=1 and `pc_load`=1 in cycle 3, `write`=0.
  - BNE: `branch_mux_s`=0.
- Illegal opcode 6'h3F at DECODE:
  - `halted`=1 next cycle; `instr_count` unchanged.
  - No further `pc_load`/`write` for 20 cycles; `reset` low clears `halted`.
- Assert `reset` during WB of ADDI: all outputs are 0 immediately, with no `write` that cycle.
- Counter wrap with `CountWidth`=4: 16 ADDIs give `instr_count`=0 with no glitch on `pc_load` cadence.
